// File: rtl/instr_fetch_unit.sv
// Instruction fetch front-end: fetch PC, in-flight address queue, instruction FIFO, redirect flush.
// Optional performance counters are enabled with `define IFU_PERF_CNT_EN.
module instr_fetch_unit #(
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    ADDR_WIDTH      = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC        = '0,
    parameter int                    FIFO_DEPTH      = 4,
    parameter int                    MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  req_valid,
    output logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_ready,
    input  logic                  rsp_valid,
    input  logic [DATA_WIDTH-1:0] rsp_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic [31:0]           fetch_count,
    output logic [31:0]           stall_count
);
    localparam int FW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int AQW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int SW  = $clog2(FIFO_DEPTH + MAX_OUTSTANDING + 1);

    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [OW-1:0]         out_q, out_d;
    logic [OW-1:0]         disc_q, disc_d;
    logic [AQW-1:0]        aq_wr_q, aq_wr_d, aq_rd_q, aq_rd_d;
    logic [FW-1:0]         wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic [ADDR_WIDTH-1:0] aq_mem   [MAX_OUTSTANDING];
    logic [DATA_WIDTH-1:0] fifo_dat [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_pc  [FIFO_DEPTH];

    logic          req_fire, rsp_keep, push, pop;
    logic [SW-1:0] occ;

    function automatic logic [AQW-1:0] aq_next(input logic [AQW-1:0] p);
        return (p == AQW'(MAX_OUTSTANDING - 1)) ? '0 : p + AQW'(1);
    endfunction

    // Credits count both buffered words and in-flight requests, so every response finds a slot.
    assign occ       = SW'(cnt_q) + SW'(out_q);
    assign req_valid = !rst && !redirect_valid && (out_q < OW'(MAX_OUTSTANDING))
                       && (occ < SW'(FIFO_DEPTH));
    assign req_addr  = fetch_pc_q;
    assign req_fire  = req_valid && req_ready;

    assign rsp_keep    = rsp_valid && !redirect_valid && (disc_q == '0);
    assign push        = rsp_keep;
    assign instr_valid = (cnt_q != '0);
    assign pop         = instr_valid && instr_ready && !redirect_valid;
    assign instr_data  = instr_valid ? fifo_dat[rd_q] : '0;
    assign instr_pc    = instr_valid ? fifo_pc[rd_q]  : '0;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        out_d      = out_q + OW'(req_fire) - OW'(rsp_valid);
        disc_d     = disc_q;
        aq_wr_d    = req_fire  ? aq_next(aq_wr_q) : aq_wr_q;
        aq_rd_d    = rsp_valid ? aq_next(aq_rd_q) : aq_rd_q;
        wr_d       = push ? wr_q + FW'(1) : wr_q;
        rd_d       = pop  ? rd_q + FW'(1) : rd_q;
        cnt_d      = cnt_q + CW'(push) - CW'(pop);
        if (redirect_valid) begin
            // Every request still in flight belongs to the abandoned path.
            fetch_pc_d = redirect_pc & ~ADDR_WIDTH'(3);
            disc_d     = out_q - OW'(rsp_valid);
            wr_d       = '0;
            rd_d       = '0;
            cnt_d      = '0;
        end else begin
            if (req_fire)
                fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
            if (rsp_valid && disc_q != '0)
                disc_d = disc_q - OW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            out_q      <= '0;
            disc_q     <= '0;
            aq_wr_q    <= '0;
            aq_rd_q    <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            out_q      <= out_d;
            disc_q     <= disc_d;
            aq_wr_q    <= aq_wr_d;
            aq_rd_q    <= aq_rd_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire)
            aq_mem[aq_wr_q] <= fetch_pc_q;
        if (push) begin
            fifo_dat[wr_q] <= rsp_data;
            fifo_pc[wr_q]  <= aq_mem[aq_rd_q];
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (pop && fetch_cnt_q != '1)
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (instr_ready && !instr_valid && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign fetch_count = fetch_cnt_q;
    assign stall_count = stall_cnt_q;
`else
    assign fetch_count = '0;
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: memory model with epoch-tagged requests, expected stream queue.
module tb_instr_fetch_unit;
    localparam int DEPTH = 4;
    localparam int MAXO  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid, instr_ready;
    logic [31:0] instr_data, instr_pc;
    logic [31:0] fetch_count, stall_count;

    instr_fetch_unit dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .instr_pc(instr_pc),
        .fetch_count(fetch_count), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; int ep; } mreq_t;
    typedef struct { logic [31:0] data; logic [31:0] pc; } sb_t;

    mreq_t       mq[$];
    sb_t         sb[$];
    int          total = 0, bad = 0;
    int          cyc = 0, lat = 1, epoch = 0, acc = 0, starve = 0;
    logic        rst_req = 1'b1, prev_rst = 1'b1, rr = 1'b1;
    logic        want_f = 1'b0;
    logic [31:0] want_pc = '0, exp_pc = '0, last_req = '0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input logic rd, input logic [31:0] rpc, input logic ird);
        sb_t   e;
        mreq_t m;
        logic  rsp_now, exp_rv;
        @(negedge clk);
        rst            = rst_req;
        rsp_now        = !rst_req && mq.size() > 0 && mq[0].due <= cyc;
        rsp_valid      = rsp_now;
        rsp_data       = rsp_now ? memf(mq[0].addr) : 32'h0;
        redirect_valid = rd && !rst_req;
        redirect_pc    = rpc;
        instr_ready    = ird;
        req_ready      = rr;
        #1;
        if (rst_req) begin
            if (prev_rst) begin
                chk("rst_req_valid", req_valid, 0);
                chk("rst_req_addr", req_addr, 32'h0);
                chk("rst_instr_valid", instr_valid, 0);
                chk("rst_instr_data", instr_data, 0);
                chk("rst_instr_pc", instr_pc, 0);
                chk("rst_fetch_cnt", fetch_count, 0);
                chk("rst_stall_cnt", stall_count, 0);
            end
            mq.delete();
            sb.delete();
            exp_pc = 32'h0; acc = 0; starve = 0; last_req = 32'h0;
        end else begin
`ifdef IFU_PERF_CNT_EN
            chk("fetch_cnt", fetch_count, acc);
            chk("stall_cnt", stall_count, starve);
`else
            chk("fetch_cnt_off", fetch_count, 0);
            chk("stall_cnt_off", stall_count, 0);
`endif
            exp_rv = !rd && mq.size() < MAXO && (sb.size() + mq.size()) < DEPTH;
            chk("ivld", instr_valid, sb.size() != 0);
            chk("req_vld", req_valid, exp_rv);
            if (ird && !instr_valid) starve++;
            if (!rd && instr_valid && ird && sb.size() > 0) begin
                e = sb.pop_front();
                chk("ipc", instr_pc, e.pc);
                chk("idata", instr_data, e.data);
                if (want_f) begin
                    chk("next_pc", instr_pc, want_pc);
                    want_f = 1'b0;
                end
                acc++;
            end
            if (rsp_now) begin
                m = mq.pop_front();
                if (!rd && m.ep == epoch) begin
                    e.data = memf(m.addr);
                    e.pc   = m.addr;
                    sb.push_back(e);
                end
            end
            if (rd) begin
                sb.delete();
                epoch++;
                exp_pc = rpc & ~32'h3;
            end else if (req_valid && rr) begin
                chk("req_addr", req_addr, exp_pc);
                if (last_req == 32'hFFFF_FFFC) chk("wrap", req_addr, 32'h0);
                last_req = req_addr;
                m.addr = req_addr; m.due = cyc + lat; m.ep = epoch;
                mq.push_back(m);
                exp_pc += 32'd4;
            end
        end
        prev_rst = rst_req;
        @(posedge clk);
        cyc++;
    endtask

    task automatic drain_mem();
        rr = 1'b0;
        for (int i = 0; i < 10 && mq.size() > 0; i++) step(0, 0, 1);
        rr = 1'b1;
    endtask

    initial begin
        int n0;
        rsp_valid = 0; rsp_data = 0; redirect_valid = 0; redirect_pc = 0;
        instr_ready = 0; req_ready = 1;
        rst_req = 1'b1;
        repeat (3) step(0, 0, 0);
        rst_req = 1'b0;

        // decode stalled: buffer fills to capacity, then drains in order
        repeat (20) step(0, 0, 0);
        chk("buffered", sb.size(), DEPTH);
        want_pc = 32'h0; want_f = 1'b1;
        repeat (25) step(0, 0, 1);
        chk("drain_seen", want_f, 0);
        n0 = acc;
        repeat (10) step(0, 0, 1);
        chk("tput", acc - n0, 10);

        // redirect with two requests in flight
        drain_mem();
        lat = 3;
        for (int i = 0; i < 20 && mq.size() != MAXO; i++) step(0, 0, 1);
        chk("out2", mq.size(), MAXO);
        want_pc = 32'h100; want_f = 1'b1;
        step(1, 32'h103, 1);
        repeat (12) step(0, 0, 1);
        chk("rdir1_seen", want_f, 0);

        // redirect coincident with a response and a ready decode
        drain_mem();
        lat = 1;
        for (int i = 0; i < 20 && !(mq.size() > 0 && mq[0].due <= cyc && sb.size() > 0); i++)
            step(0, 0, 1);
        chk("rsp_pend", mq.size() > 0 && mq[0].due <= cyc && sb.size() > 0, 1);
        want_pc = 32'h200; want_f = 1'b1;
        step(1, 32'h200, 1);
        repeat (8) step(0, 0, 1);
        chk("rdir2_seen", want_f, 0);

        // back-to-back redirects, then address wrap
        step(1, 32'h300, 1);
        want_pc = 32'h400; want_f = 1'b1;
        step(1, 32'h400, 1);
        repeat (8) step(0, 0, 1);
        chk("rdir3_seen", want_f, 0);
        want_pc = 32'hFFFF_FFF8; want_f = 1'b1;
        step(1, 32'hFFFF_FFF9, 1);
        repeat (10) step(0, 0, 1);
        chk("wrap_seen", want_f, 0);

        // mid-operation reset, then counters from a clean start
        rst_req = 1'b1;
        repeat (2) step(0, 0, 1);
        rst_req = 1'b0;
        repeat (3) step(0, 0, 1);
        repeat (4) step(0, 0, 0);
        repeat (10) step(0, 0, 1);
        step(0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
